hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32 core. Owns the stall and flush decisions for the IF/ID and ID/EX pipeline registers, the PC and EX/MEM register enables. It detects load-use hazards against the instruction held in ID/EX and applies branch-taken flushes. It also freezes the whole pipeline while the data memory has not acknowledged a MEM-stage access, and traps a memory timeout. Two saturating performance counters are included.

---
 rtl/core_pkg.sv | 13 +
 rtl/sat_counter.sv | 35 +++
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the core pipeline control blocks.
// Holds the hazard controller state encoding and register-file constants.
package core_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage : core_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Registered output, one cycle from inc/clr to new value; no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencing: load-use bubbles, branch flushes, dmem freeze, timeout trap.
// Control outputs are combinational (zero latency); err and perf counters are registered.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_re,
    input  logic [4:0]       ex_addr_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             dmem_ack,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                WCNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);

    hz_state_t         state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    logic load_use;
    logic run_rows;
    logic branch_row;

    assign load_use = ex_mem_re && (ex_addr_rd != REG_X0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_addr_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_addr_rd)));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        run_rows    = 1'b0;
        branch_row  = 1'b0;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req && !dmem_ack) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end else begin
                    run_rows = 1'b1;
                end
            end
            MEM_WAIT: begin
                // The ack cycle itself is resolved as a normal RUN cycle.
                if (dmem_ack) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    run_rows   = 1'b1;
                end else if (wait_cnt_q == TIMEOUT_V) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            ERROR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = ERROR;
                err_d   = 1'b1;
            end
        endcase

        if (run_rows) begin
            if (ex_branch_taken) begin
                // The killed ID instruction cannot cause a load-use stall.
                branch_row  = 1'b1;
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
            end else if (load_use) begin
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
            end else begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
            end
        end

        if (!reset_n) begin
            branch_row  = 1'b0;
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b0;
            id_ex_en    = 1'b0;
            id_ex_flush = 1'b0;
            ex_mem_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (!pc_en),
        .clr     (cnt_clr),
        .cnt     (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (branch_row),
        .clr     (cnt_clr),
        .cnt     (flush_count)
    );

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a per-cycle expectation queue and a counter model.
module tb_hazard_ctrl;

    localparam int MT = 4;
    localparam int CW = 4;

    localparam logic [5:0] C_NORM = 6'b110101;
    localparam logic [5:0] C_BR   = 6'b111111;
    localparam logic [5:0] C_LU   = 6'b000111;
    localparam logic [5:0] C_STOP = 6'b000000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [4:0]    id_rs1, id_rs2, ex_addr_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_re, ex_branch_taken;
    logic          mem_req, dmem_ack, cnt_clr;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, err;
    logic [CW-1:0] stall_cycles, flush_count;
    logic [5:0]    ctrl;

    typedef struct {
        logic [5:0] ctrl;
        logic       clr;
        logic       err;
    } exp_t;

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    logic [CW-1:0] m_stall  = '0;
    logic [CW-1:0] m_flush  = '0;

    always #5 clk = ~clk;

    assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en};

    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_re       (ex_mem_re),
        .ex_addr_rd      (ex_addr_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .dmem_ack        (dmem_ack),
        .cnt_clr         (cnt_clr),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .if_id_flush     (if_id_flush),
        .id_ex_en        (id_ex_en),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_en       (ex_mem_en),
        .err             (err),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic chk(input string tag, input int got, input int exp_v);
        checks++;
        assert (got === exp_v) else begin
            failures++;
            $error("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp_v);
        end
    endtask

    // Called just after a rising edge with inputs already driven for this cycle.
    task automatic cyc(input logic [5:0] e_ctrl, input logic e_err);
        exp_t e;
        sb.push_back('{ctrl: e_ctrl, clr: cnt_clr, err: e_err});
        #3;
        e = sb.pop_front();
        checks++;
        assert (ctrl === e.ctrl) else begin
            failures++;
            $error("FAIL ctrl t=%0t got=%b exp=%b", $time, ctrl, e.ctrl);
        end
        if (e.clr) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (!e.ctrl[5] && (m_stall != '1)) m_stall = m_stall + 1'b1;
            if (e.ctrl[3] && (m_flush != '1)) m_flush = m_flush + 1'b1;
        end
        @(posedge clk);
        #1;
        chk("err", int'(err), int'(e.err));
        chk("stall_cycles", int'(stall_cycles), int'(m_stall));
        chk("flush_count", int'(flush_count), int'(m_flush));
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_re = 1'b0; ex_addr_rd = 5'd0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; dmem_ack = 1'b0; cnt_clr = 1'b0;
    endtask

    initial begin
        // Reset with active-looking inputs: everything must stay quiet.
        idle_inputs();
        reset_n = 1'b0;
        ex_branch_taken = 1'b1;
        mem_req = 1'b1;
        #2;
        chk("rst_ctrl", int'(ctrl), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_stall", int'(stall_cycles), 0);
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();
        reset_n = 1'b1;

        cyc(C_NORM, 1'b0);

        // Load-use on rs1, then the bubble in EX releases it.
        ex_mem_re = 1'b1; ex_addr_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        cyc(C_LU, 1'b0);
        chk("lu_stall_cnt", int'(stall_cycles), 1);
        ex_mem_re = 1'b0;
        cyc(C_NORM, 1'b0);

        // Load-use on rs2; no hazard when rs2 is not read.
        ex_mem_re = 1'b1; ex_addr_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1; id_uses_rs1 = 1'b0;
        cyc(C_LU, 1'b0);
        id_uses_rs2 = 1'b0;
        cyc(C_NORM, 1'b0);

        // Load into x0 never stalls.
        ex_addr_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        cyc(C_NORM, 1'b0);

        // Branch together with a load-use match: only the flush applies.
        ex_addr_rd = 5'd9; id_rs1 = 5'd9; ex_branch_taken = 1'b1;
        cyc(C_BR, 1'b0);
        chk("br_flush_cnt", int'(flush_count), 1);
        chk("br_stall_cnt", int'(stall_cycles), 2);

        idle_inputs();
        cnt_clr = 1'b1;
        cyc(C_NORM, 1'b0);
        cnt_clr = 1'b0;

        // Memory wait of 3 cycles with a branch pending throughout.
        ex_branch_taken = 1'b1;
        mem_req = 1'b1;
        cyc(C_STOP, 1'b0);
        mem_req = 1'b0;
        cyc(C_STOP, 1'b0);
        cyc(C_STOP, 1'b0);
        dmem_ack = 1'b1;
        cyc(C_BR, 1'b0);
        chk("mw_stall_cnt", int'(stall_cycles), 3);
        chk("mw_flush_cnt", int'(flush_count), 1);

        // Same-cycle ack: no stall, stays in RUN.
        ex_branch_taken = 1'b0;
        mem_req = 1'b1; dmem_ack = 1'b1;
        cyc(C_NORM, 1'b0);
        mem_req = 1'b0; dmem_ack = 1'b0;
        cyc(C_NORM, 1'b0);
        chk("ack0_stall_cnt", int'(stall_cycles), 3);

        // Timeout: ack never arrives.
        cnt_clr = 1'b1;
        cyc(C_NORM, 1'b0);
        cnt_clr = 1'b0;
        mem_req = 1'b1;
        cyc(C_STOP, 1'b0);
        mem_req = 1'b0;
        cyc(C_STOP, 1'b0);
        cyc(C_STOP, 1'b0);
        cyc(C_STOP, 1'b0);
        cyc(C_STOP, 1'b1);

        // ERROR ignores ack and branch; stall counter saturates.
        dmem_ack = 1'b1; ex_branch_taken = 1'b1;
        for (int i = 0; i < 20; i++) cyc(C_STOP, 1'b1);
        chk("sat_stall_cnt", int'(stall_cycles), 15);
        cnt_clr = 1'b1;
        cyc(C_STOP, 1'b1);
        chk("clr_stall_cnt", int'(stall_cycles), 0);
        cnt_clr = 1'b0;
        cyc(C_STOP, 1'b1);

        // Asynchronous reset from ERROR, mid-cycle.
        reset_n = 1'b0;
        #1;
        chk("arst_ctrl", int'(ctrl), 0);
        chk("arst_err", int'(err), 0);
        chk("arst_stall", int'(stall_cycles), 0);
        chk("arst_flush", int'(flush_count), 0);
        m_stall = '0;
        m_flush = '0;
        #1;
        idle_inputs();
        reset_n = 1'b1;
        cyc(C_NORM, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hazard_ctrl
